// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Receive end of the enable-framed single-wire serial link. A frame starts on
//   the falling edge of ena_i; WIDTH data bits are sampled LSB-first every
//   BIT_CYCLES clocks, starting SAMPLE_OFFSET clocks after the start edge.
//   Completed words go into a DEPTH-entry FIFO drained over valid/ready.
//
//   Optional feature macro: SERIAL_FRAME_RX_PARITY_EN
//     Adds one even-parity bit after the data bits; a mismatching word is
//     dropped and flagged on frame_err_o.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active low
//   ena_i        frame enable, frame active while low
//   data_i       serial data, LSB first
//   data_o       FIFO head word (registered)
//   valid_o      FIFO not empty
//   ready_i      consumer accept; pop on valid_o && ready_i
//   count_o      FIFO occupancy, 0..DEPTH
//   ovf_o        1-clock pulse: completed word dropped, FIFO full
//   frame_err_o  1-clock pulse: frame aborted (or parity failure)
module serial_frame_rx #(
  parameter int WIDTH         = 10,
  parameter int BIT_CYCLES    = 2,
  parameter int SAMPLE_OFFSET = 1,
  parameter int DEPTH         = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     ena_i,
  input  logic                     data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ovf_o,
  output logic                     frame_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(BIT_CYCLES) + 1;
  localparam int BW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, OFFSET, SHIFT, CHECK, PUSH, WAIT_HIGH} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [BW-1:0]   bit_cnt, bit_n;
  logic            ena_q;
  logic [WIDTH-1:0] shreg;
  logic            sample, push_req, abort;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic            psample, parity_q;
`endif

  // FSM state and counters
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      ena_q   <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      ena_q   <= ena_i;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_cnt;
    sample   = 1'b0;
    push_req = 1'b0;
    abort    = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    psample  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (ena_q && !ena_i) begin
          bit_n = '0;
          // With a 1-clock offset the first sample lands on the very next edge,
          // so OFFSET is skipped entirely.
          if (SAMPLE_OFFSET == 1) begin
            state_n = SHIFT;
            cnt_n   = '0;
          end else begin
            state_n = OFFSET;
            cnt_n   = CW'(SAMPLE_OFFSET - 2);
          end
        end
      end
      OFFSET: begin
        if (ena_i)              abort = 1'b1;
        else if (cnt == '0)     state_n = SHIFT;
        else                    cnt_n = cnt - 1'b1;
      end
      SHIFT: begin
        if (ena_i) abort = 1'b1;
        else if (cnt == '0) begin
          sample = 1'b1;
          cnt_n  = CW'(BIT_CYCLES - 1);
          if (bit_cnt == BW'(WIDTH - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            state_n = CHECK;
`else
            state_n = PUSH;
`endif
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end else cnt_n = cnt - 1'b1;
      end
`ifdef SERIAL_FRAME_RX_PARITY_EN
      CHECK: begin
        if (ena_i) abort = 1'b1;
        else if (cnt == '0) begin
          psample = 1'b1;
          state_n = PUSH;
        end else cnt_n = cnt - 1'b1;
      end
`endif
      PUSH: begin
        state_n = WAIT_HIGH;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        // Parity verdict is taken one clock after the parity sample.
        if (parity_q == ^shreg) push_req = 1'b1;
        else                    abort    = 1'b1;
`else
        push_req = 1'b1;
`endif
      end
      WAIT_HIGH: if (ena_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  // Deserializer: shift in from the top so bit 0 ends at the LSB.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      shreg <= '0;
    end else if (sample) begin
      shreg <= {data_i, shreg[WIDTH-1:1]};
    end
  end

`ifdef SERIAL_FRAME_RX_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       parity_q <= 1'b0;
    else if (psample) parity_q <= data_i;
  end
`endif

  // FIFO
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
  logic             pop, full, push, ovf_n;
  logic [WIDTH-1:0] head_n;

  assign valid_o = (count_o != '0);
  assign pop     = valid_o && ready_i;
  assign full    = (count_o == (AW+1)'(DEPTH));
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push    = push_req && (!full || pop);
  assign ovf_n   = push_req && full && !pop;
  assign rd_nxt  = pop ? rd_ptr + 1'b1 : rd_ptr;
  // Incoming word becomes the head when it lands in the slot rd_nxt points at.
  assign head_n  = (push && (wr_ptr == rd_nxt)) ? shreg : mem[rd_nxt];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_o     <= '0;
      data_o      <= '0;
      ovf_o       <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_nxt;
      case ({push, pop})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
      data_o      <= head_n;
      ovf_o       <= ovf_n;
      frame_err_o <= abort;
    end
  end

endmodule
